// File: rtl/buck_boost_mode_ctrl_if.sv
// Control/data bundle between the converter supervisor and the H-bridge mode controller.
// master drives ADC samples and requests; slave returns mode, duty and status.
interface buck_boost_mode_ctrl_if #(
  parameter int ADC_W = 12
);
  logic             enable;
  logic             fault_in;
  logic             period_tick;
  logic             adc_valid;
  logic [ADC_W-1:0] vin_code;
  logic [ADC_W-1:0] vout_code;
  logic [ADC_W-1:0] vref_code;
  logic [1:0]       mode;
  logic [7:0]       duty;
  logic             ss_done;
  logic             fault_latch;
  logic [2:0]       state_dbg;

  modport master (
    output enable, fault_in, period_tick, adc_valid, vin_code, vout_code, vref_code,
    input  mode, duty, ss_done, fault_latch, state_dbg
  );

  modport slave (
    input  enable, fault_in, period_tick, adc_valid, vin_code, vout_code, vref_code,
    output mode, duty, ss_done, fault_latch, state_dbg
  );
endinterface

// File: rtl/buck_boost_mode_ctrl.sv
// Buck/boost mode supervisor: picks the H-bridge mode from Vin/Vref, soft-starts and
// regulates the PWM duty on period boundaries, inserts OFF dead periods and latches faults.
module buck_boost_mode_ctrl #(
  parameter int ADC_W    = 12,
  parameter int HYST     = 16,
  parameter int DB       = 4,
  parameter int STEP     = 1,
  parameter int DUTY_MIN = 8,
  parameter int DUTY_MAX = 240,
  parameter int SS_DIV   = 4,
  parameter int DEAD_PER = 2,
  parameter int VIN_MAX  = 4000
) (
  input logic                   sys_clk,
  input logic                   rst,
  buck_boost_mode_ctrl_if.slave bus
);
  // state      | meaning
  // IDLE       | converter off, waiting for enable at a period tick
  // SOFT_START | duty ceiling ramps from DUTY_MIN toward DUTY_MAX
  // RUN        | closed-loop regulation over the full duty range
  // SWITCH     | OFF dead periods between two operating modes
  // FAULT      | latched fault, bridge off
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SOFT   = 3'd1,
    S_RUN    = 3'd2,
    S_SWITCH = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  localparam int CW = ADC_W + 2;
  localparam logic [CW-1:0] HYST_W = CW'(HYST);
  localparam logic [CW-1:0] DB_W   = CW'(DB);
  localparam logic [CW-1:0] VMAX_W = CW'(VIN_MAX);
  localparam logic [7:0] D_MIN     = 8'(DUTY_MIN);
  localparam logic [7:0] D_MAX     = 8'(DUTY_MAX);
  localparam logic [7:0] STEP_8    = 8'(STEP);
  localparam logic [7:0] SS_LOAD   = 8'(SS_DIV - 1);
  localparam logic [7:0] DEAD_LOAD = 8'(DEAD_PER - 1);
  localparam logic [1:0] M_OFF = 2'b00, M_BUCK = 2'b01, M_BOOST = 2'b10, M_BB = 2'b11;

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d, tgt_q, tgt_now;
  logic [7:0]       duty_q, duty_d, ceil_q, ceil_d;
  logic [7:0]       ss_cnt_q, ss_cnt_d, dead_q, dead_d;
  logic [ADC_W-1:0] vin_q, vout_q;
  logic             fresh_q, fresh_clr, ss_done_q, fault_q;
  logic [CW-1:0]    vin_w, vout_w, vref_w, vref2_w;
  logic             buck_set, boost_set, bb_set, reg_up, reg_dn, fault_cond, ceil_bump;
  logic [7:0]       ceil_step, hi, reg_duty;
  logic [9:0]       d_inc;

  assign vin_w   = {2'b00, vin_q};
  assign vout_w  = {2'b00, vout_q};
  assign vref_w  = {2'b00, bus.vref_code};
  assign vref2_w = vref_w << 1;

  // Outside both hysteresis bands a mode is forced; inside a band the last target holds.
  assign buck_set  = vin_w > vref2_w + HYST_W;
  assign boost_set = vin_w + HYST_W < vref_w;
  assign bb_set    = (vin_w + HYST_W < vref2_w) && (vin_w > vref_w + HYST_W);

  always_comb begin
    tgt_now = tgt_q;
    if (buck_set)       tgt_now = M_BUCK;
    else if (boost_set) tgt_now = M_BOOST;
    else if (bb_set)    tgt_now = M_BB;
  end

  assign fault_cond = bus.fault_in || (vin_w > VMAX_W);
  assign reg_up     = fresh_q && (vout_w + DB_W < vref_w);
  assign reg_dn     = fresh_q && (vout_w > vref_w + DB_W);
  assign ceil_bump  = (ss_cnt_q == 8'd0);
  assign ceil_step  = ceil_bump ? ceil_q + 8'd1 : ceil_q;
  assign hi         = (state_q == S_SOFT) ? ceil_step : D_MAX;
  assign d_inc      = {2'b00, duty_q} + {2'b00, STEP_8};

  always_comb begin
    reg_duty = duty_q;
    if (reg_up)      reg_duty = (d_inc > {2'b00, hi}) ? hi : d_inc[7:0];
    else if (reg_dn) reg_duty = (duty_q < D_MIN + STEP_8) ? D_MIN : duty_q - STEP_8;
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    duty_d    = duty_q;
    ceil_d    = ceil_q;
    ss_cnt_d  = ss_cnt_q;
    dead_d    = dead_q;
    fresh_clr = 1'b0;
    if (fault_cond) begin
      state_d = S_FAULT;
      mode_d  = M_OFF;
      duty_d  = 8'd0;
    end else if (state_q == S_FAULT) begin
      if (bus.period_tick && !bus.enable) state_d = S_IDLE;
    end else if (!bus.enable) begin
      state_d = S_IDLE;
      mode_d  = M_OFF;
      duty_d  = 8'd0;
    end else if (bus.period_tick) begin
      case (state_q)
        S_IDLE: begin
          state_d  = S_SOFT;
          mode_d   = tgt_now;
          duty_d   = D_MIN;
          ceil_d   = D_MIN;
          ss_cnt_d = SS_LOAD;
        end
        S_SOFT, S_RUN: begin
          if (tgt_now != mode_q) begin
            state_d = S_SWITCH;
            mode_d  = M_OFF;
            duty_d  = 8'd0;
            dead_d  = DEAD_LOAD;
          end else begin
            duty_d    = reg_duty;
            fresh_clr = 1'b1;
            if (state_q == S_SOFT) begin
              ceil_d   = ceil_step;
              ss_cnt_d = ceil_bump ? SS_LOAD : ss_cnt_q - 8'd1;
              if (ceil_step >= D_MAX) state_d = S_RUN;
            end
          end
        end
        S_SWITCH: begin
          if (dead_q == 8'd0) begin
            state_d  = S_SOFT;
            mode_d   = tgt_now;
            duty_d   = D_MIN;
            ceil_d   = D_MIN;
            ss_cnt_d = SS_LOAD;
          end else begin
            dead_d = dead_q - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= M_OFF;
      duty_q    <= 8'd0;
      ceil_q    <= D_MIN;
      ss_cnt_q  <= SS_LOAD;
      dead_q    <= 8'd0;
      tgt_q     <= M_BB;
      vin_q     <= '0;
      vout_q    <= '0;
      fresh_q   <= 1'b0;
      ss_done_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      duty_q    <= duty_d;
      ceil_q    <= ceil_d;
      ss_cnt_q  <= ss_cnt_d;
      dead_q    <= dead_d;
      tgt_q     <= tgt_now;
      ss_done_q <= (state_d == S_RUN);
      fault_q   <= (state_d == S_FAULT);
      // A sample arriving on a tick is latched after the tick has used the old one.
      if (bus.adc_valid) begin
        vin_q   <= bus.vin_code;
        vout_q  <= bus.vout_code;
        fresh_q <= 1'b1;
      end else if (fresh_clr) begin
        fresh_q <= 1'b0;
      end
    end
  end

  assign bus.mode        = mode_q;
  assign bus.duty        = duty_q;
  assign bus.ss_done     = ss_done_q;
  assign bus.fault_latch = fault_q;
  assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_buck_boost_mode_ctrl.sv
// Bench for buck_boost_mode_ctrl: directed scenarios plus randomized traffic, checked
// through a scoreboard fed by an event-level reference model.
module tb_buck_boost_mode_ctrl;
  localparam int HYST = 16, DB = 4, STEP = 1, DUTY_MIN = 8, DUTY_MAX = 240;
  localparam int SS_DIV = 4, DEAD_PER = 2, VIN_MAX = 4000;
  localparam int ST_IDLE = 0, ST_SOFT = 1, ST_RUN = 2, ST_SWITCH = 3, ST_FAULT = 4;

  typedef struct {
    int cyc;
    int mode;
    int duty;
    int st;
  } exp_t;

  logic sys_clk = 1'b0;
  logic rst;
  buck_boost_mode_ctrl_if #(.ADC_W(12)) bus ();

  buck_boost_mode_ctrl dut (.sys_clk(sys_clk), .rst(rst), .bus(bus));

  always #5 sys_clk = ~sys_clk;

  int cyc_cnt = 0;
  always @(posedge sys_clk) cyc_cnt <= cyc_cnt + 1;

  int checks = 0, errors = 0;
  exp_t sb_q[$];

  // stimulus state
  bit en, flt, en_prev;
  int vin_s, vout_s, vref_s;

  // reference model state
  int m_state, m_mode, m_duty, m_ss_ticks, m_dead, m_vin, m_vout, m_tgt;
  bit m_fresh;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int tgt_fn(input int vin, input int vref, input int cur);
    if (vin > 2 * vref + HYST) return 1;
    if (vin + HYST < vref) return 2;
    if ((vin + HYST < 2 * vref) && (vin > vref + HYST)) return 3;
    return cur;
  endfunction

  task automatic model_reset();
    m_state = ST_IDLE; m_mode = 0; m_duty = 0; m_ss_ticks = 0; m_dead = 0;
    m_vin = 0; m_vout = 0; m_fresh = 0; m_tgt = 3;
  endtask

  task automatic enter_soft(input int tgt);
    m_state = ST_SOFT; m_mode = tgt; m_duty = DUTY_MIN; m_ss_ticks = 0;
  endtask

  // One clock edge of the converter rules, using the samples latched before this edge.
  task automatic model_step(input bit tick, input bit av, input bit e, input bit f,
                            input int vin, input int vout, input int vref);
    int tgt, ceil, hi;
    bit used;
    used = 0;
    tgt = tgt_fn(m_vin, vref, m_tgt);
    if (f || m_vin > VIN_MAX) begin
      m_state = ST_FAULT; m_mode = 0; m_duty = 0;
    end else if (m_state == ST_FAULT) begin
      if (tick && !e) m_state = ST_IDLE;
    end else if (!e) begin
      m_state = ST_IDLE; m_mode = 0; m_duty = 0;
    end else if (tick) begin
      if (m_state == ST_IDLE) begin
        enter_soft(tgt);
      end else if (m_state == ST_SWITCH) begin
        m_dead++;
        if (m_dead == DEAD_PER) enter_soft(tgt);
      end else if (tgt != m_mode) begin
        m_state = ST_SWITCH; m_mode = 0; m_duty = 0; m_dead = 0;
      end else begin
        if (m_state == ST_SOFT) m_ss_ticks++;
        ceil = DUTY_MIN + m_ss_ticks / SS_DIV;
        hi = (m_state == ST_SOFT) ? ceil : DUTY_MAX;
        if (m_fresh) begin
          used = 1;
          if (m_vout + DB < vref) m_duty = (m_duty + STEP > hi) ? hi : m_duty + STEP;
          else if (m_vout > vref + DB)
            m_duty = (m_duty - STEP < DUTY_MIN) ? DUTY_MIN : m_duty - STEP;
        end
        if (m_state == ST_SOFT && ceil >= DUTY_MAX) m_state = ST_RUN;
      end
    end
    m_tgt = tgt;
    if (used) m_fresh = 0;
    if (av) begin
      m_vin = vin; m_vout = vout; m_fresh = 1;
    end
  endtask

  task automatic step(input bit tick, input bit av);
    exp_t ex;
    bus.period_tick = tick;
    bus.adc_valid   = av;
    bus.enable      = en;
    bus.fault_in    = flt;
    bus.vin_code    = 12'(vin_s);
    bus.vout_code   = 12'(vout_s);
    bus.vref_code   = 12'(vref_s);
    model_step(tick, av, en, flt, vin_s, vout_s, vref_s);
    if (tick || flt || en != en_prev || $urandom_range(0, 15) == 0) begin
      ex.cyc = cyc_cnt + 1; ex.mode = m_mode; ex.duty = m_duty; ex.st = m_state;
      sb_q.push_back(ex);
    end
    en_prev = en;
    @(negedge sys_clk);
  endtask

  task automatic period(input int len, input int adc_at, input int flt_at);
    for (int c = 0; c < len; c++) begin
      flt = (c == flt_at);
      step(c == len - 1, c == adc_at);
    end
    flt = 0;
  endtask

  task automatic periods(input int n);
    for (int i = 0; i < n; i++) period(4, 1, -1);
  endtask

  // monitor: compares DUT outputs against the scoreboard entry due in this cycle
  initial begin
    exp_t ex;
    bit bad;
    forever begin
      @(negedge sys_clk);
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc_cnt) begin
        ex = sb_q.pop_front();
        checks++;
        bad = (int'(bus.mode) != ex.mode) || (int'(bus.duty) != ex.duty) ||
              (int'(bus.state_dbg) != ex.st) || (bus.ss_done != (ex.st == ST_RUN)) ||
              (bus.fault_latch != (ex.st == ST_FAULT));
        if (bad) begin
          errors++;
          $display("FAIL sb cyc %0d mode/duty/state/ss_done/fault got %0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d",
                   cyc_cnt, bus.mode, bus.duty, bus.state_dbg, bus.ss_done, bus.fault_latch,
                   ex.mode, ex.duty, ex.st, ex.st == ST_RUN, ex.st == ST_FAULT);
        end
      end
    end
  end

  initial begin
    int vin_tab[15];
    int len, adc_at, flt_at;
    vin_tab = '{900, 975, 983, 990, 1010, 1017, 1500, 1983, 1985, 1999, 2016, 2017, 2100, 3000, 4050};
    rst = 1'b1; en = 0; flt = 0; en_prev = 0;
    vin_s = 2100; vout_s = 900; vref_s = 1000;
    bus.period_tick = 0; bus.adc_valid = 0; bus.enable = 0; bus.fault_in = 0;
    bus.vin_code = 0; bus.vout_code = 0; bus.vref_code = 12'(vref_s);
    repeat (3) @(negedge sys_clk);
    check("rst_mode", int'(bus.mode), 0);
    check("rst_duty", int'(bus.duty), 0);
    check("rst_state", int'(bus.state_dbg), ST_IDLE);
    check("rst_ss_done", int'(bus.ss_done), 0);
    check("rst_fault", int'(bus.fault_latch), 0);
    rst = 1'b0;
    model_reset();

    // idle with enable low, then soft start in BUCK
    periods(3);
    check("idle_state", int'(bus.state_dbg), ST_IDLE);
    en = 1;
    periods(1);
    check("ss_entry_mode", int'(bus.mode), 1);
    check("ss_entry_duty", int'(bus.duty), DUTY_MIN);
    periods(927);
    check("ramp_927_duty", int'(bus.duty), 239);
    check("ramp_927_ss_done", int'(bus.ss_done), 0);
    periods(1);
    check("ramp_928_duty", int'(bus.duty), 240);
    check("ramp_928_ss_done", int'(bus.ss_done), 1);

    // hysteresis around the buck threshold, then dead periods into BUCK_BOOST
    vin_s = 1990; periods(5);
    check("hyst_hold_mode", int'(bus.mode), 1);
    vin_s = 1980; periods(1);
    check("dead1_mode", int'(bus.mode), 0);
    check("dead1_state", int'(bus.state_dbg), ST_SWITCH);
    periods(1);
    check("dead2_mode", int'(bus.mode), 0);
    periods(1);
    check("bb_mode", int'(bus.mode), 3);
    check("bb_duty", int'(bus.duty), DUTY_MIN);
    periods(930);
    check("bb_run", int'(bus.ss_done), 1);

    // regulation in RUN: down, deadband edges, up, clamp at DUTY_MAX
    vout_s = 1100; periods(20);
    check("reg_down", int'(bus.duty), 220);
    vout_s = 1004; periods(10);
    check("db_hi_hold", int'(bus.duty), 220);
    vout_s = 996; periods(10);
    check("db_lo_hold", int'(bus.duty), 220);
    vout_s = 980; periods(5);
    check("reg_up", int'(bus.duty), 225);
    vout_s = 500; periods(30);
    check("clamp_max", int'(bus.duty), 240);
    step(0, 1); step(0, 0);
    vout_s = 1100; step(1, 1);
    check("tick_uses_old_sample", int'(bus.duty), 240);
    step(0, 0); step(0, 0); step(1, 0);
    check("new_sample_next_tick", int'(bus.duty), 239);

    // asynchronous reset in RUN
    #2 rst = 1'b1;
    #1;
    check("async_rst_mode", int'(bus.mode), 0);
    check("async_rst_duty", int'(bus.duty), 0);
    check("async_rst_state", int'(bus.state_dbg), ST_IDLE);
    @(negedge sys_clk); @(negedge sys_clk);
    rst = 1'b0;
    model_reset();
    vout_s = 900; vin_s = 2100;

    // one-cycle external fault pulse, latched until enable drops at a tick
    periods(3);
    period(6, 0, 2);
    check("fault_state", int'(bus.state_dbg), ST_FAULT);
    check("fault_latch", int'(bus.fault_latch), 1);
    check("fault_duty", int'(bus.duty), 0);
    periods(3);
    check("fault_held", int'(bus.fault_latch), 1);
    en = 0; periods(1);
    check("fault_exit", int'(bus.state_dbg), ST_IDLE);

    // input over-voltage
    en = 1; periods(2);
    vin_s = 4050; periods(1);
    check("ov_fault", int'(bus.state_dbg), ST_FAULT);
    vin_s = 3000; en = 0; periods(1);
    check("ov_exit", int'(bus.state_dbg), ST_IDLE);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      len = $urandom_range(3, 8);
      adc_at = $urandom_range(0, len) - 1;
      flt_at = ($urandom_range(0, 40) == 0) ? $urandom_range(0, len - 1) : -1;
      vin_s = vin_tab[($urandom_range(0, 13) == 0) ? 14 : $urandom_range(0, 13)];
      vout_s = $urandom_range(950, 1050);
      if ($urandom_range(0, 50) == 0) vref_s = $urandom_range(700, 1300);
      en = ($urandom_range(0, 15) != 0);
      period(len, adc_at, flt_at);
    end

    en = 0;
    step(0, 0); step(0, 0); step(0, 0);
    check("sb_drain", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
